sync_fifo_param: RTL
====================

# sync_fifo_param

Parametrised synchronous FIFO, the next-generation buffer for the APB-UART Tx and Rx data paths. Adds configurable width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and a sticky error flag with separate overflow/underflow causes. An optional first-word-fall-through read mode is available at compile time.

## Interface
- DATABUS, 8: data width in bits.
- DEPTH, 16: number of entries; power of two, ≥ 2.
- AFULL_TH, DEPTH-2: almost_full asserts when level ≥ AFULL_TH.
- AEMPTY_TH, 2: almost_empty asserts when level ≤ AEMPTY_TH.
- ADDRBUS, $clog2(DEPTH): derived; not for override.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- push  in  1  write request.
- push_data_in  in  DATABUS  write data, sampled when a push is accepted.
- pop  in  1  read request.
- pop_data_out  out  DATABUS  read data.
- flush  in  1  synchronous clear of contents.
- err_clr  in  1  clears the sticky error bits.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- almost_empty  out  1  level ≤ AEMPTY_TH.
- almost_full  out  1  level ≥ AFULL_TH.
- level  out  ADDRBUS+1  current occupancy, 0..DEPTH.
- err  out  1  sticky error: overflow | underflow.
- err_cause  out  2  {underflow, overflow} sticky bits.

## Operation
- Storage: DEPTH×DATABUS register array. Write and read pointers are ADDRBUS+1 bits; the MSB is the wrap bit. level = wr_ptr − rd_ptr, taken modulo 2^(ADDRBUS+1).
- Push accepted: push && (!full || pop). Entry written at wr_ptr[ADDRBUS-1:0]; wr_ptr increments.
- Pop accepted: pop && !empty. rd_ptr increments.
- Full with push && pop: both are accepted and level is unchanged.
- Empty with push && pop: the push is accepted, the pop is rejected, and underflow is flagged.
- Push rejected while full sets err_cause[0] (overflow). The array and pointers are unchanged.
- Pop rejected while empty sets err_cause[1] (underflow). pop_data_out holds its value.
- err = |err_cause. err_clr clears both bits. A new error in the same cycle as err_clr wins and the bit stays set.
- flush: both pointers go to 0 on the next edge. flush has priority over push/pop in that cycle; those requests are dropped and not flagged. flush does not clear err_cause.
- All flags are decoded from the registered pointers, so they update on the same edge as level.

## Timing
- Reset values: pointers 0; level 0; empty 1; almost_empty 1; full 0; almost_full 0; err 0; err_cause 0; pop_data_out 0. Array contents are not reset.
- Write-to-visibility: after a push at edge N, empty deasserts after edge N. The data can be popped starting in cycle N+1.
- Default read (no FWFT): pop_data_out is registered. It takes the head entry on the edge where the pop is accepted, so latency is 1 cycle. It holds between pops.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous). The FIFO is empty on release.
- Back-to-back push or pop on every cycle is sustained at one transfer per clock.

## Configuration
- FIFO_FWFT_EN defined: pop_data_out = mem[rd_ptr] combinationally, so the head is visible whenever !empty. pop acts as an acknowledge, and the next entry appears in the cycle after an accepted pop. Value while empty is don't-care.
- FIFO_FWFT_EN undefined: registered 1-cycle read as described in Timing.

## Structure
- Package fifo_pkg holds:
  - error-cause bit indices (ERR_OVF=0, ERR_UDF=1);
  - a level-width helper function;
  - default parameter constants shared with the UART top.
- One sub-module, fifo_flags: takes the pointers and thresholds and produces level, empty, full, almost_empty and almost_full. It is purely combinational and reused by the Rx path.
- Storage and pointer/error logic live in sync_fifo_param.

## Test plan
- Defaults (DATABUS=8, DEPTH=16). Reset, then push 0xA5, 0x3C, 0x7E, then pop 3 → outputs 0xA5, 0x3C, 0x7E in order (1-cycle latency); level goes 3→0; empty returns to 1; err stays 0.
- Push 16 entries 0x00..0x0F → full=1, level=16, almost_full from the 14th push on. A 17th push of 0xFF → err=1, err_cause=2'b01. Then pop 16 → 0x00..0x0F, with 0xFF never seen.
- Pop while empty → err_cause=2'b10 and pop_data_out unchanged. err_clr for 1 cycle → err=0. err_clr in the same cycle as a new underflow → err stays 1.
- Full FIFO with push 0x55 and pop in the same cycle → level stays 16, no error. Oldest entry leaves; 0x55 becomes the newest.
- Fill 10 entries, then flush with push high in the same cycle → level=0, empty=1, almost_empty=1, no error, and the pushed word is not stored. Repeat with rst_n pulsed low mid-burst → same result.
- Pointer wrap: 40 interleaved push/pop of an incrementing pattern at level ≈ 5 → data in order, no errors. Rerun with FIFO_FWFT_EN defined → head visible without a pop, with the same data order.

Source files
------------

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the parametrised synchronous FIFO and the
// UART top that instantiates it.
//   ERR_OVF / ERR_UDF : bit positions inside err_cause
//   DEF_DATABUS       : default data width
//   DEF_DEPTH         : default number of entries
//   level_width()     : bits needed to hold an occupancy of 0..depth
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int ERR_OVF = 0;
    localparam int ERR_UDF = 1;

    localparam int DEF_DATABUS = 8;
    localparam int DEF_DEPTH   = 16;

    // Pointers carry one extra wrap bit, so occupancy 0..depth needs the same.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_flags.sv
// ---------------------------------------------------------------------------
// fifo_flags
// Purely combinational occupancy decode from a pair of wrap-bit pointers.
// Shared by the Tx and Rx FIFOs.
//   wr_ptr, rd_ptr   in  : ADDRBUS+1 bit pointers, MSB is the wrap bit
//   afull_th         in  : almost_full when level >= afull_th
//   aempty_th        in  : almost_empty when level <= aempty_th
//   level            out : wr_ptr - rd_ptr, 0..DEPTH
//   empty, full      out : level == 0 / level == DEPTH
//   almost_empty     out
//   almost_full      out
// ---------------------------------------------------------------------------
module fifo_flags
    import fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic [level_width(DEPTH)-1:0] wr_ptr,
    input  logic [level_width(DEPTH)-1:0] rd_ptr,
    input  logic [level_width(DEPTH)-1:0] afull_th,
    input  logic [level_width(DEPTH)-1:0] aempty_th,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full
);

    localparam int PTRW = level_width(DEPTH);

    // Modulo-2^PTRW subtraction handles pointer wrap without any compare.
    assign level        = wr_ptr - rd_ptr;
    assign empty        = (level == '0);
    assign full         = (level == PTRW'(DEPTH));
    assign almost_empty = (level <= aempty_th);
    assign almost_full  = (level >= afull_th);

endmodule : fifo_flags

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param
// Parametrised synchronous FIFO with occupancy, thresholds, flush and a
// sticky overflow/underflow error.
// Compile-time option: FIFO_FWFT_EN -- when defined, pop_data_out shows the
// head entry combinationally (first-word-fall-through); otherwise it is a
// registered read with one cycle of latency that holds between pops.
//   clk, rst_n        : clock, asynchronous active-low reset
//   push/push_data_in : write request and data
//   pop/pop_data_out  : read request and data
//   flush             : synchronous clear of contents (errors kept)
//   err_clr           : clear sticky error bits
//   empty, full, almost_empty, almost_full, level : occupancy status
//   err, err_cause    : sticky error, {underflow, overflow}
// ---------------------------------------------------------------------------
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATABUS   = DEF_DATABUS,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [DATABUS-1:0]            push_data_in,
    input  logic                          pop,
    output logic [DATABUS-1:0]            pop_data_out,
    input  logic                          flush,
    input  logic                          err_clr,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          err,
    output logic [1:0]                    err_cause
);

    localparam int ADDRBUS = $clog2(DEPTH);
    localparam int PTRW    = level_width(DEPTH);

    logic [DATABUS-1:0] mem_q [DEPTH];

    logic [PTRW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [1:0]         err_cause_q, err_cause_d;
    logic [1:0]         new_err;
    logic               push_ok, pop_ok;
    logic [ADDRBUS-1:0] wr_idx, rd_idx;

    assign wr_idx = wr_ptr_q[ADDRBUS-1:0];
    assign rd_idx = rd_ptr_q[ADDRBUS-1:0];

    fifo_flags #(.DEPTH(DEPTH)) u_flags (
        .wr_ptr       (wr_ptr_q),
        .rd_ptr       (rd_ptr_q),
        .afull_th     (PTRW'(AFULL_TH)),
        .aempty_th    (PTRW'(AEMPTY_TH)),
        .level        (level),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full)
    );

    // A simultaneous pop frees the slot, so a push into a full FIFO is
    // accepted when paired with a pop.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        new_err  = '0;
        if (flush) begin
            // Flush wins: push/pop requests this cycle are dropped unflagged.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTRW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTRW'(1);
            new_err[ERR_OVF] = push && !push_ok;
            new_err[ERR_UDF] = pop && !pop_ok;
        end
        // A fresh error in the err_clr cycle is OR-ed in after the clear.
        err_cause_d = (err_clr ? 2'b00 : err_cause_q) | new_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            err_cause_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_cause_q <= err_cause_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and leaving it out keeps it a plain register file.
    always_ff @(posedge clk) begin
        if (!flush && push_ok) mem_q[wr_idx] <= push_data_in;
    end

    assign err_cause = err_cause_q;
    assign err       = |err_cause_q;

`ifdef FIFO_FWFT_EN
    // Head entry is visible as soon as it is written; contents while empty
    // are stale and meaningless.
    assign pop_data_out = mem_q[rd_idx];
`else
    logic [DATABUS-1:0] dout_q, dout_d;

    always_comb begin
        dout_d = dout_q;
        if (!flush && pop_ok) dout_d = mem_q[rd_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout_q <= '0;
        else        dout_q <= dout_d;
    end

    assign pop_data_out = dout_q;
`endif

endmodule : sync_fifo_param
